// File: rtl/alu_issue.sv
// Issue sequencer between decode and the ALU: fetches operands from the register file,
// runs one instruction through the ALU and writes the result and flags back.
module alu_issue #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              instr_ar,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_opcode,
  output logic              alu_ar_flag,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_out_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, READ, OPER, EXEC, WB} state_t;

  localparam logic [3:0] OP_DIV = 4'h6;

  state_t            state;
  logic [REG_AW-1:0] rd_q;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'h3) && (op <= 4'hB);
  endfunction

  // rf_wdata doubles as the captured ALU result, so no separate result register is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      rd_q        <= '0;
      rf_raddr1   <= '0;
      rf_raddr2   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      alu_opcode  <= 4'h0;
      alu_ar_flag <= 1'b0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      alu_out_en  <= 1'b0;
      flags       <= 4'h0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_ready <= 1'b0;
            alu_opcode  <= instr[15:12];
            alu_ar_flag <= instr_ar;
            rd_q        <= instr[8 +: REG_AW];
            rf_raddr1   <= instr[4 +: REG_AW];
            rf_raddr2   <= instr[0 +: REG_AW];
            if (is_legal(instr[15:12])) begin
              state <= READ;
            end else begin
              state <= WB;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        READ: begin
          state <= OPER;
        end
        OPER: begin
          // Division by zero is caught here so the ALU never sees it.
          if ((alu_opcode == OP_DIV) && (rf_rdata2 == '0)) begin
            state <= WB;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            alu_src1   <= rf_rdata1;
            alu_src2   <= rf_rdata2;
            alu_out_en <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          alu_out_en <= 1'b0;
          rf_wdata   <= alu_out;
          rf_waddr   <= rd_q;
          rf_we      <= 1'b1;
          done       <= 1'b1;
          state      <= WB;
        end
        WB: begin
          if (!err) begin
            flags <= alu_flags;
          end
          rf_we       <= 1'b0;
          rf_waddr    <= '0;
          rf_wdata    <= '0;
          done        <= 1'b0;
          err         <= 1'b0;
          alu_opcode  <= 4'h0;
          alu_ar_flag <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: register-file and ALU models, scoreboard-driven monitor.
module tb_alu_issue;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = 16'h0000;
  logic          instr_ar = 1'b0;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [3:0]    alu_opcode;
  logic          alu_ar_flag;
  logic [DW-1:0] alu_src1, alu_src2;
  logic          alu_out_en;
  logic [DW-1:0] alu_out;
  logic [3:0]    alu_flags = 4'h0;
  logic [3:0]    flags;
  logic          done, err;

  alu_issue #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_ar(instr_ar), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_out_en(alu_out_en), .alu_out(alu_out),
    .alu_flags(alu_flags), .flags(flags), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        err;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          acc_q[$];
  int          acc_log[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          out_en_cnt = 0;
  int          we_cnt = 0;
  logic        flag_chk = 1'b0;
  logic [3:0]  flag_exp = 4'h0;
  string       flag_name = "";
  logic [15:0] regs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ALU reference: {O,C,N,Z} and result. Opcode 3=ADD, 4=SUB, 6=DIV.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        o, c;
    w = 17'h0; o = 1'b0; c = 1'b0;
    case (op)
      4'h3: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h4: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h6: r = (b != 16'h0) ? a / b : 16'h0;
      default: r = a;
    endcase
    return {o, c, r[15], (r == 16'h0), r};
  endfunction

  assign alu_out = alu_fn(alu_opcode, alu_src1, alu_src2)[15:0];

  // Register file (one-cycle read latency), ALU flag register, accept log.
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
    if (rf_we) regs[rf_waddr] = rf_wdata;
    if (alu_out_en) alu_flags <= alu_fn(alu_opcode, alu_src1, alu_src2)[19:16];
    if (!rst && instr_valid && instr_ready) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
    cyc++;
  end

  // Monitor: pops the scoreboard on every done pulse, checks flags one cycle later.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (alu_out_en) out_en_cnt++;
    if (rf_we) we_cnt++;
    if (flag_chk) begin
      chk({flag_name, "_flags"}, {28'h0, flags}, {28'h0, flag_exp});
      flag_chk = 1'b0;
    end
    if (!rst && done) begin
      if (sb.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_done", {31'h0, done}, 32'h0);
      end else begin
        e = sb.pop_front();
        a = acc_q.pop_front();
        chk({e.name, "_err"}, {31'h0, err}, {31'h0, e.err});
        chk({e.name, "_we"}, {31'h0, rf_we}, {31'h0, !e.err});
        chk({e.name, "_latency"}, cyc - a, e.lat);
        if (!e.err) begin
          chk({e.name, "_waddr"}, {28'h0, rf_waddr}, {28'h0, e.waddr});
          chk({e.name, "_wdata"}, {16'h0, rf_wdata}, {16'h0, e.wdata});
        end
        flag_exp  = e.flags;
        flag_name = e.name;
        flag_chk  = 1'b1;
      end
    end else if (!rst && rf_we) begin
      chk("stray_we", {31'h0, rf_we}, 32'h0);
    end
  end

  task automatic wait_accept(input int n0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_log.size() > n0) break;
    end
    chk("accept_seen", {31'h0, acc_log.size() > n0}, 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !flag_chk) break;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] ins, input exp_t e);
    int n0;
    n0 = acc_log.size();
    sb.push_back(e);
    instr       = ins;
    instr_valid = 1'b1;
    wait_accept(n0);
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    drain();
  endtask

  initial begin
    int oe0;
    int n0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_we", {31'h0, rf_we}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_out_en", {31'h0, alu_out_en}, 32'h0);
    chk("rst_opcode", {28'h0, alu_opcode}, 32'h0);

    // 1: ADD r3 = r1 + r2
    regs[1] = 16'h0005; regs[2] = 16'h0003;
    issue(16'h3312, '{"add", 4'd3, 16'h0008, 1'b0, 4'b0000, 4});
    chk("add_reg3", {16'h0, regs[3]}, 32'h0008);

    // 2: SUB r4 = r1 - r1, single out_en pulse
    regs[1] = 16'h1234;
    oe0 = out_en_cnt;
    issue(16'h4411, '{"sub", 4'd4, 16'h0000, 1'b0, 4'b0001, 4});
    chk("sub_out_en_pulses", out_en_cnt - oe0, 1);

    // 3: DIV r5 = r1 / r2 with r2 == 0
    regs[2] = 16'h0000;
    oe0 = out_en_cnt;
    issue(16'h6512, '{"div0", 4'd5, 16'h0000, 1'b1, 4'b0001, 3});
    chk("div0_out_en_pulses", out_en_cnt - oe0, 0);
    chk("div0_reg5", {16'h0, regs[5]}, 32'h0);

    // 4: illegal opcode
    oe0 = out_en_cnt;
    issue(16'hF123, '{"illegal", 4'd1, 16'h0000, 1'b1, 4'b0001, 1});
    chk("illegal_out_en_pulses", out_en_cnt - oe0, 0);

    // 5: reset in EXEC of an ADD aborts it
    regs[1] = 16'h0005; regs[2] = 16'h0003;
    n0 = acc_log.size();
    instr = 16'h3812; instr_valid = 1'b1;
    wait_accept(n0);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_exec", {31'h0, alu_out_en}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    chk("abort_ready", {31'h0, instr_ready}, 32'h1);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_we", {31'h0, rf_we}, 32'h0);
    chk("abort_flags", {28'h0, flags}, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_reg8", {16'h0, regs[8]}, 32'h0);

    // 6: back-to-back with valid held high; second reads the first's result
    regs[1] = 16'h1234; regs[2] = 16'h0003;
    sb.push_back('{"b2b_1", 4'd6, 16'h1237, 1'b0, 4'b0000, 4});
    sb.push_back('{"b2b_2", 4'd7, 16'h246E, 1'b0, 4'b0000, 4});
    n0 = acc_log.size();
    instr = 16'h3612; instr_valid = 1'b1;
    wait_accept(n0);
    instr = 16'h3766;
    wait_accept(n0 + 1);
    instr_valid = 1'b0;
    if (acc_log.size() >= n0 + 2)
      chk("b2b_gap", acc_log[n0 + 1] - acc_log[n0], 5);
    drain();
    chk("b2b_reg7", {16'h0, regs[7]}, 32'h246E);

    chk("total_we_pulses", we_cnt, 4);
    chk("total_out_en_pulses", out_en_cnt, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
